pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 120 ++++++++++++
 tb/tb_pc_fetch.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// pc_fetch: program-counter holder and single-outstanding instruction fetcher.
// Latency: fetch issues the cycle after reset release or advance; word held the edge after imem_rvalid.
// Backpressure: stall holds the fetched word/PC in HOLD; imem_req stays up until imem_rvalid.
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   npc_in              - next PC, loaded when the held instruction is consumed
//   stall               - core not ready; keeps the held instruction
//   imem_req/imem_addr  - instruction read request and byte address (= cur_pc)
//   imem_rvalid/rdata   - returned instruction word
//   cur_pc, pc_next     - PC of held instruction and cur_pc+4
//   instr, instr_valid  - held instruction and its valid flag
//   fetch_cnt           - completed fetches (wrapping)
//   misalign_err        - sticky misaligned-PC flag
//
// Build option: define PC_FETCH_MISALIGN_TRAP_EN to trap on a misaligned
// next PC (enter ERR until reset). Without it the low two PC bits are cleared
// on load and misalign_err is constant 0.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc_in,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] cur_pc,
  output logic [31:0] pc_next,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] fetch_cnt,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t state;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

  // The request address is the PC itself, so it is stable for the whole FETCH.
  assign imem_addr = cur_pc;
  assign pc_next   = cur_pc + 32'd4;

  // imem_req and instr_valid are registered next to the state so they change
  // exactly on state transitions (and drop immediately on reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_pc      <= RESET_PC;
      instr       <= '0;
      fetch_cnt   <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            fetch_cnt   <= fetch_cnt + 32'd1;
            state       <= HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_valid <= 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            // Keep the offending PC visible for debug rather than masking it.
            cur_pc <= npc_in;
            if (npc_in[1:0] != 2'b00) begin
              misalign_q <= 1'b1;
              state      <= ERR;
            end else begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end
`else
            cur_pc   <= {npc_in[31:2], 2'b00};
            state    <= FETCH;
            imem_req <= 1'b1;
`endif
          end
        end
        ERR: begin
          // Dead until reset: no requests, nothing valid, PC frozen.
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: self-checking bench for pc_fetch with a flag-based reference model.
// Inputs are driven 1 time unit after the rising edge; outputs are compared there too.
// Summary line reports total comparisons and failures.
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] npc_in;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] cur_pc;
  logic [31:0] pc_next;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] fetch_cnt;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  pc_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .npc_in       (npc_in),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .cur_pc       (cur_pc),
    .pc_next      (pc_next),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .fetch_cnt    (fetch_cnt),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: "waiting" = a read is outstanding, "have" = a word is
  // held for the core, "dead" = trapped until reset.
  bit          m_started, m_waiting, m_have, m_dead, m_err;
  logic [31:0] m_pc, m_instr, m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started <= 0; m_waiting <= 0; m_have <= 0; m_dead <= 0; m_err <= 0;
      m_pc <= 32'h0000_3000; m_instr <= 32'h0; m_cnt <= 32'h0;
    end else if (m_dead) begin
      m_dead <= 1;
    end else if (!m_started) begin
      m_started <= 1;
      m_waiting <= 1;
    end else if (m_waiting) begin
      if (imem_rvalid) begin
        m_instr   <= imem_rdata;
        m_cnt     <= m_cnt + 32'd1;
        m_waiting <= 0;
        m_have    <= 1;
      end
    end else if (m_have && !stall) begin
      m_have <= 0;
      if (TRAP && npc_in[1:0] != 2'b00) begin
        m_pc   <= npc_in;
        m_err  <= 1;
        m_dead <= 1;
      end else begin
        m_pc      <= npc_in & 32'hFFFF_FFFC;
        m_waiting <= 1;
      end
    end
  end

  logic [162:0] obs, expv;
  localparam logic [162:0] RST_VEC = {3'b000, 32'h0000_3000, 32'h0000_3000,
                                      32'h0000_3004, 32'h0, 32'h0};
  assign obs = {imem_req, instr_valid, misalign_err, imem_addr, cur_pc, pc_next, instr, fetch_cnt};
  always_comb expv = {m_waiting, m_have, m_err, m_pc, m_pc, m_pc + 32'd4, m_instr, m_cnt};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; stall = 0; imem_rvalid = 0; imem_rdata = 0; npc_in = 0;
    #2;
    repeat (2) cyc();
    checks++;
    if (obs !== RST_VEC) begin
      failures++; $display("FAIL reset_state got=%h want=%h", obs, RST_VEC);
    end
    checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL reset_model got=%h want=%h", obs, expv);
    end
    rst_n = 1;
  endtask

  // Cycle 1 = IDLE (from release), cycle 2 = FETCH with rvalid, cycle 3 = HOLD.
  task automatic test_first_fetch();
    logic [31:0] w;
    w = $urandom;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL idle_req got=%b want=0", imem_req);
    end
    cyc();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
      failures++; $display("FAIL first_req got=%b/%h want=1/00003000", imem_req, imem_addr);
    end
    imem_rvalid = 1; imem_rdata = w;
    cyc();
    imem_rvalid = 0; stall = 1;
    checks++;
    if (instr_valid !== 1'b1 || instr !== w || fetch_cnt !== 32'd1) begin
      failures++;
      $display("FAIL first_hold got=%b/%h/%0d want=1/%h/1", instr_valid, instr, fetch_cnt, w);
    end
    checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL first_model got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_stall();
    logic [31:0] spc, sins, tgt;
    spc = cur_pc; sins = instr;
    for (int i = 0; i < 5; i++) begin
      npc_in = $urandom & 32'hFFFF_FFFC;
      cyc();
      checks++;
      if (cur_pc !== spc || instr !== sins || instr_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold got=%h/%h/%b want=%h/%h/1", cur_pc, instr, instr_valid, spc, sins);
      end
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL stall_model got=%h want=%h", obs, expv);
      end
    end
    tgt = $urandom & 32'hFFFF_FFFC;
    stall = 0; npc_in = tgt;
    cyc();
    stall = 1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== tgt || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release got=%b/%h/%b want=1/%h/0", imem_req, imem_addr, instr_valid, tgt);
    end
  endtask

  task automatic test_delay();
    logic [31:0] saddr, scnt, w;
    saddr = imem_addr; scnt = fetch_cnt; w = $urandom;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== saddr || fetch_cnt !== scnt) begin
        failures++;
        $display("FAIL delay_wait got=%b/%h/%0d want=1/%h/%0d", imem_req, imem_addr, fetch_cnt, saddr, scnt);
      end
      cyc();
    end
    imem_rvalid = 1; imem_rdata = w;
    cyc();
    imem_rvalid = 0;
    checks++;
    if (fetch_cnt !== scnt + 32'd1 || instr !== w || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL delay_done got=%0d/%h/%b want=%0d/%h/1", fetch_cnt, instr, instr_valid, scnt + 1, w);
    end
    cyc();
    checks++;
    if (fetch_cnt !== scnt + 32'd1) begin
      failures++; $display("FAIL delay_once got=%0d want=%0d", fetch_cnt, scnt + 1);
    end
  endtask

  task automatic test_wrap();
    stall = 0; npc_in = 32'hFFFF_FFFC;
    cyc();
    stall = 1;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || pc_next !== 32'h0) begin
      failures++; $display("FAIL wrap_pc got=%h/%h want=fffffffc/00000000", imem_addr, pc_next);
    end
    imem_rvalid = 1; imem_rdata = $urandom;
    cyc();
    imem_rvalid = 0;
    checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL wrap_model got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom % 3) == 0;
      imem_rvalid = ($urandom % 3) != 0;
      imem_rdata  = $urandom;
      npc_in      = $urandom;
      if (TRAP) npc_in[1:0] = 2'b00;
      cyc();
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL random_%0d got=%h want=%h", i, obs, expv);
      end
    end
    imem_rvalid = 0; stall = 1;
  endtask

  task automatic test_misalign();
    int n;
    logic [31:0] scnt;
    n = 0;
    stall = 1;
    while (instr_valid !== 1'b1 && n < 50) begin
      imem_rvalid = 1; imem_rdata = $urandom;
      cyc();
      n++;
    end
    imem_rvalid = 0;
    checks++;
    if (n >= 50) begin
      failures++; $display("FAIL reach_hold got=timeout want=instr_valid");
    end
    scnt = fetch_cnt;
    stall = 0; npc_in = 32'h0000_3002;
    cyc();
    if (TRAP) begin
      checks++;
      if (misalign_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || cur_pc !== 32'h0000_3002) begin
        failures++;
        $display("FAIL misalign_trap got=%b/%b/%b/%h want=1/0/0/00003002", misalign_err, imem_req, instr_valid, cur_pc);
      end
      for (int i = 0; i < 4; i++) begin
        imem_rvalid = 1; stall = i[0]; npc_in = $urandom;
        cyc();
        checks++;
        if (imem_req !== 1'b0 || fetch_cnt !== scnt || cur_pc !== 32'h0000_3002 || misalign_err !== 1'b1) begin
          failures++;
          $display("FAIL err_stuck got=%b/%0d/%h/%b want=0/%0d/00003002/1", imem_req, fetch_cnt, cur_pc, misalign_err, scnt);
        end
      end
      imem_rvalid = 0;
    end else begin
      checks++;
      if (imem_addr !== 32'h0000_3000 || imem_req !== 1'b1 || misalign_err !== 1'b0) begin
        failures++;
        $display("FAIL misalign_mask got=%h/%b/%b want=00003000/1/0", imem_addr, imem_req, misalign_err);
      end
    end
    checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL misalign_model got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_reset_mid_fetch();
    rst_n = 0; imem_rvalid = 0; stall = 0;
    cyc();
    rst_n = 1;
    cyc();
    checks++;
    if (imem_req !== 1'b1) begin
      failures++; $display("FAIL pre_reset_fetch got=%b want=1", imem_req);
    end
    #3;
    rst_n = 0;
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      failures++; $display("FAIL async_reset got=%h want=%h", obs, RST_VEC);
    end
    imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0;
    cyc();
    checks++;
    if (obs !== RST_VEC) begin
      failures++; $display("FAIL reset_hold got=%h want=%h", obs, RST_VEC);
    end
    rst_n = 1;
    cyc();
    imem_rvalid = 0;
    checks++;
    if (fetch_cnt !== 32'd0 || instr !== 32'd0 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL stray_rvalid got=%0d/%h/%b/%b want=0/00000000/1/0", fetch_cnt, instr, imem_req, instr_valid);
    end
    checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL post_reset_model got=%h want=%h", obs, expv);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_delay();
    test_wrap();
    test_random();
    test_misalign();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
